// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: drives a shared 4-bit ALU slice one nibble per clock to
// perform WIDTH-bit AND/OR/ADD/SUB/SLT, with a second pass on nibble 0 for SLT.
module alu_nibble_sequencer #(
  parameter int WIDTH = 16,
  localparam int NIB = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  output logic             slice_less,
  output logic [2:0]       slice_op,
  input  logic [3:0]       slice_result,
  input  logic             slice_cout,
  input  logic             slice_set
);
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, SLTFIX, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_result, w_acc_next;
  logic [2:0]       r_op;
  logic [IW-1:0]    r_idx;
  logic             r_carry, r_set, r_cout, r_zero, w_legal, w_last;
  assign w_legal = op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
  assign w_last  = r_idx == IW'(NIB - 1);
  // Merge the slice's nibble into the accumulator at the current index.
  assign w_acc_next = (r_acc & ~(WIDTH'(4'hF) << {r_idx, 2'b00})) |
                      (WIDTH'(slice_result) << {r_idx, 2'b00});
  assign result = r_result;
  assign cout   = r_cout;
  assign zero   = r_zero;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    slice_a    = '0;
    slice_b    = '0;
    slice_cin  = 1'b0;
    slice_less = 1'b0;
    slice_op   = '0;
    case (r_state)
      IDLE: if (start) w_next = w_legal ? RUN : DONE;
      RUN: begin
        busy      = 1'b1;
        slice_a   = 4'(r_a >> {r_idx, 2'b00});
        slice_b   = 4'(r_b >> {r_idx, 2'b00});
        slice_cin = r_carry;
        slice_op  = r_op;
        if (w_last) w_next = (r_op == 3'b111) ? SLTFIX : DONE;
      end
      SLTFIX: begin
        busy       = 1'b1;
        slice_a    = r_a[3:0];
        slice_b    = r_b[3:0];
        slice_cin  = 1'b1;
        slice_less = r_set;
        slice_op   = 3'b111;
        w_next     = DONE;
      end
      default: begin
        done   = 1'b1;
        w_next = IDLE;
      end
    endcase
  end
  // Visible result/cout/zero load only on the edge entering DONE.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_set    <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          if (w_legal) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_idx   <= '0;
            r_carry <= op[2];
            r_acc   <= '0;
          end else begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b1;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= slice_cout;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_set <= slice_set;
            if (r_op != 3'b111) begin
              r_result <= w_acc_next;
              r_cout   <= r_op[1] & ~r_op[0] & slice_cout;
              r_zero   <= w_acc_next == '0;
            end
          end
        end
        SLTFIX: begin
          r_result <= WIDTH'(slice_result);
          r_cout   <= 1'b0;
          r_zero   <= slice_result == 4'h0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: directed vectors against a behavioural 4-bit slice model.
module tb_alu_nibble_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] a = '0, b = '0, result;
  logic [2:0]  op = '0, slice_op;
  logic        busy, done, cout, zero, slice_cin, slice_less, slice_cout, slice_set;
  logic [3:0]  slice_a, slice_b, slice_result;
  logic [4:0]  w_sum;
  int          n_vec = 0, n_err = 0;

  alu_nibble_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_less(slice_less), .slice_op(slice_op), .slice_result(slice_result),
    .slice_cout(slice_cout), .slice_set(slice_set)
  );

  always #5 clk = ~clk;

  // Slice: adder sees ~b when op[2]; SLT outputs only the less bit.
  always_comb begin
    w_sum = {1'b0, slice_a} + {1'b0, slice_op[2] ? ~slice_b : slice_b} + 5'(slice_cin);
    slice_cout = w_sum[4];
    slice_set  = w_sum[3];
    case (slice_op)
      3'b000:         slice_result = slice_a & slice_b;
      3'b001:         slice_result = slice_a | slice_b;
      3'b010, 3'b110: slice_result = w_sum[3:0];
      3'b111:         slice_result = {3'b000, slice_less};
      default:        slice_result = 4'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                     input logic [15:0] er, input logic ec, input int el, input bit inj);
    int lat = 0, extra = 0;
    logic [15:0] prev = result;
    bit stable = 1'b1;
    op = o; a = x; b = y; start = 1'b1;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (inj && k == 2) begin start = 1'b1; op = 3'b001; a = 16'h0000; b = 16'hFFFF; end
      if (inj && k == 3) start = 1'b0;
      if (done) lat = k;
      else if (result !== prev) stable = 1'b0;
    end
    chk({tag, "/latency"}, lat, el);
    chk({tag, "/result"}, result, er);
    chk({tag, "/cout"}, cout, ec);
    chk({tag, "/zero"}, zero, er == 16'h0);
    chk({tag, "/busy_at_done"}, busy, 1'b0);
    chk({tag, "/stable_while_busy"}, stable, 1'b1);
    repeat (inj ? 7 : 1) begin
      @(posedge clk); #1;
      extra += int'(done);
    end
    chk({tag, "/extra_done"}, extra, 0);
    chk({tag, "/result_held"}, result, er);
  endtask

  initial begin
    int dn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/busy", busy, 1'b0);
    chk("reset/done", done, 1'b0);
    chk("reset/result", result, 16'h0000);
    chk("reset/cout", cout, 1'b0);
    chk("reset/zero", zero, 1'b1);
    chk("reset/slice_op", slice_op, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("add_carry_nibble", 3'b010, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 5, 1'b0);
    run("add_wrap",         3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 5, 1'b0);
    run("sub_borrow",       3'b110, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 5, 1'b0);
    run("sub_pos",          3'b110, 16'h0007, 16'h0005, 16'h0002, 1'b1, 5, 1'b0);
    run("slt_true",         3'b111, 16'h0003, 16'h0009, 16'h0001, 1'b0, 6, 1'b0);
    run("slt_false",        3'b111, 16'h0009, 16'h0003, 16'h0000, 1'b0, 6, 1'b0);
    run("and_ignored_start",3'b000, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 5, 1'b1);
    run("or",               3'b001, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 5, 1'b0);
    run("illegal_100",      3'b100, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1, 1'b0);
    run("add_msb_ovf",      3'b010, 16'h8000, 16'h8000, 16'h0000, 1'b1, 5, 1'b0);
    run("sub_equal",        3'b110, 16'h1234, 16'h1234, 16'h0000, 1'b1, 5, 1'b0);
    run("add_mixed",        3'b010, 16'h1234, 16'h1111, 16'h2345, 1'b0, 5, 1'b0);
    op = 3'b010; a = 16'h1234; b = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("midrun/busy_before", busy, 1'b1);
    chk("midrun/slice_a_before", slice_a, 4'h3);
    rst_n = 1'b0;
    #1;
    chk("midrun/busy", busy, 1'b0);
    chk("midrun/result", result, 16'h0000);
    chk("midrun/zero", zero, 1'b1);
    chk("midrun/cout", cout, 1'b0);
    chk("midrun/slice_a", slice_a, 4'h0);
    chk("midrun/slice_cin", slice_cin, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      dn += int'(done);
    end
    chk("midrun/no_done", dn, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("after_reset_add",  3'b010, 16'h0001, 16'h0001, 16'h0002, 1'b0, 5, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Multi-cycle controller that drives an external 4-bit ALU slice, one nibble per clock, to perform WIDTH-bit AND/OR/ADD/SUB/SLT.
- Supplies the slice's operand nibbles, carry-in, less and op, then collects its result, cout and set.
- Sits between the datapath issue logic and a single shared slice; replaces a WIDTH-bit ripple/CLA array where area matters.

Parameters:
- WIDTH, 16, operand width; must be a multiple of 4, minimum 4.
- NIB, WIDTH/4, nibble count (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; captured on accepted start
- b  in  WIDTH  operand B; captured on accepted start
- op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  final result; held until next accepted start
- cout  out  1  carry out of top nibble (ADD/SUB); 0 otherwise
- zero  out  1  1 iff result == 0
- slice_a  out  4  nibble of A to slice
- slice_b  out  4  nibble of B to slice
- slice_cin  out  1  slice carry-in
- slice_less  out  1  slice less input (bit 0)
- slice_op  out  3  op to slice
- slice_result  in  4  slice result (combinational from slice_* outputs)
- slice_cout  in  1  slice carry-out
- slice_set  in  1  slice MSB adder sum bit

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result=0, cout=0, zero=1; all slice_* outputs 0; internal index and carry registers 0.
- States: IDLE, RUN, SLTFIX, DONE.
- IDLE:
  - start=1 with a legal op: capture a, b and op; index=0; carry=op[2] (1 for SUB/SLT); go to RUN.
  - start=1 with an illegal op (011, 100, 101): go directly to DONE with result=0, cout=0, zero=1.
- RUN, index i:
  - slice_a=a_reg[4i+3:4i], slice_b=b_reg[4i+3:4i], slice_cin=carry, slice_less=0, slice_op=op_reg.
  - At the clock edge: result nibble i <= slice_result; carry <= slice_cout; i <= i+1.
  - When i=NIB-1: latch set_reg <= slice_set. Then go to SLTFIX if op is SLT, otherwise DONE.
- SLTFIX (one cycle):
  - Re-issue nibble 0 with slice_less=set_reg, slice_cin=1, slice_op=111.
  - result <= {zeros, slice_result}; go to DONE.
- DONE (one cycle):
  - done=1; cout=carry for ADD/SUB, else 0; zero=(result==0).
  - busy drops in this same cycle; go to IDLE.
- Latency, start edge to done high: NIB+1 cycles (5 at WIDTH=16); SLT NIB+2; illegal op 1.
- Start handling:
  - start is ignored whenever the state is not IDLE, including in DONE.
  - Back-to-back start is accepted on the first IDLE cycle after DONE.
- SLT uses the raw MSB of A−B (no overflow correction), matching slice set semantics.
- Wrap-around:
  - ADD overflow discards the top carry into cout.
  - SUB borrow is indicated by cout=0.
- Reset asserted mid-RUN/SLTFIX: abort immediately to the reset values above; no done pulse.
- Outputs result/cout/zero update only at DONE; they are stable during busy.

Test Plan (WIDTH=16, behavioural slice model attached):
- ADD a=0x00FF b=0x0001 -> done 5 cycles after start; result=0x0100, cout=0, zero=0.
- ADD a=0xFFFF b=0x0001 -> result=0x0000, cout=1, zero=1.
- SUB a=0x0005 b=0x0007 -> result=0xFFFE, cout=0; then SUB 0x0007−0x0005 -> 0x0002, cout=1.
- SLT a=0x0003 b=0x0009 -> result=0x0001 with done 6 cycles after start; SLT a=0x0009 b=0x0003 -> result=0x0000, zero=1.
- AND 0xF0F0,0x3C3C -> 0x3030, followed by OR -> 0xFCFC.
  - A start pulse issued while busy is ignored: exactly one done pulse per accepted start, and result is unchanged by the ignored request.
- Reset driven low in RUN cycle 2 -> busy=0, result=0, zero=1, no done.
  - Illegal op 100 -> done 1 cycle later with result=0, zero=1, cout=0.
